// File: rtl/liteeth_sram_pkg.sv
// liteeth_sram_pkg: shared SRAM macro geometry for the liteeth FIFO controller
package liteeth_sram_pkg;
  localparam int SRAM_BITS = 32;
  localparam int SRAM_DEPTH = 384;
  localparam int SRAM_AW = 9;
  localparam int LEVEL_W = 10;
endpackage

// File: rtl/liteeth_sram_fifo_obuf.sv
// liteeth_sram_fifo_obuf: 2-entry capture/pop buffer hiding the SRAM read latency
module liteeth_sram_fifo_obuf import liteeth_sram_pkg::*; #(
  parameter int BITS = SRAM_BITS
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  input  logic            rd_en,
  output logic [1:0]      cnt,
  output logic [BITS-1:0] head
);
  logic [BITS-1:0] e0, e1;
  logic [1:0] wr_idx;
  assign wr_idx = cnt - {1'b0, rd_en};
  assign head = e0;
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      if (rd_en) e0 <= e1;
      if (wr_en && wr_idx == 2'd0) e0 <= wr_data;
      if (wr_en && wr_idx == 2'd1) e1 <= wr_data;
      cnt <= cnt + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end
endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// liteeth_sram_fifo_ctrl: sequences a 1rw1r SRAM macro as a single-clock streaming FIFO
module liteeth_sram_fifo_ctrl import liteeth_sram_pkg::*; #(
  parameter int BITS = SRAM_BITS,
  parameter int WORD_DEPTH = SRAM_DEPTH,
  parameter int ADDR_WIDTH = SRAM_AW,
  parameter int LEVEL_WIDTH = LEVEL_W
) (
  input  logic                   clk0,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [BITS-1:0]        s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [BITS-1:0]        m_data,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   mem_ce_rw,
  output logic                   mem_we_rw,
  output logic [BITS-1:0]        mem_wmask,
  output logic [ADDR_WIDTH-1:0]  mem_addr_rw,
  output logic [BITS-1:0]        mem_wdata,
  output logic                   mem_ce_r,
  output logic [ADDR_WIDTH-1:0]  mem_addr_r,
  input  logic [BITS-1:0]        mem_rdata
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] FULL = LEVEL_WIDTH'(WORD_DEPTH);
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [LEVEL_WIDTH-1:0] mem_cnt, mem_cnt_n;
  logic [1:0] ob_cnt, ob_cnt_n;
  logic inflight, clr, push, issue, pop;
  always_comb begin
    clr = rst | flush;
    s_ready = !clr && mem_cnt != FULL;
    push = s_valid && s_ready;
    m_valid = !clr && ob_cnt != 2'd0;
    pop = m_valid && m_ready;
    issue = !clr && mem_cnt != '0 && ({1'b0, ob_cnt} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
    mem_cnt_n = mem_cnt + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(issue);
    ob_cnt_n = ob_cnt + {1'b0, inflight} - {1'b0, pop};
  end
  assign mem_ce_rw = push;
  assign mem_we_rw = push;
  assign mem_wmask = '1;
  assign mem_addr_rw = wptr;
  assign mem_wdata = s_data;
  assign mem_ce_r = issue;
  assign mem_addr_r = rptr;
  always_ff @(posedge clk0) begin
    if (clr) begin
      wptr <= '0;
      rptr <= '0;
      mem_cnt <= '0;
      inflight <= 1'b0;
      level <= '0;
    end else begin
      wptr <= push ? (wptr == LAST ? '0 : wptr + 1'b1) : wptr;
      rptr <= issue ? (rptr == LAST ? '0 : rptr + 1'b1) : rptr;
      mem_cnt <= mem_cnt_n;
      inflight <= issue;
      level <= mem_cnt_n + LEVEL_WIDTH'(issue) + LEVEL_WIDTH'(ob_cnt_n);
    end
  end
  liteeth_sram_fifo_obuf #(.BITS(BITS)) u_obuf (
    .clk(clk0),
    .clr(clr),
    .wr_en(inflight),
    .wr_data(mem_rdata),
    .rd_en(pop),
    .cnt(ob_cnt),
    .head(m_data)
  );
endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// tb_liteeth_sram_fifo_ctrl: directed checks of the SRAM FIFO controller with a behavioural SRAM
module tb_liteeth_sram_fifo_ctrl;
  logic clk0 = 1'b0;
  logic rst, flush, s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data, m_data, mem_wmask, mem_wdata, mem_rdata;
  logic [9:0] level;
  logic mem_ce_rw, mem_we_rw, mem_ce_r;
  logic [8:0] mem_addr_rw, mem_addr_r, prev_addr;
  logic [31:0] ram [0:383];
  int total = 0, passed = 0, fails = 0;
  int accepted, got, errs, sent, bubbles, maxlvl;
  logic wrap, started, seen;
  always #5 clk0 = ~clk0;
  always @(posedge clk0) begin
    if (mem_ce_rw && mem_we_rw) ram[mem_addr_rw] <= mem_wdata;
    if (mem_ce_r) mem_rdata <= ram[mem_addr_r];
  end
  liteeth_sram_fifo_ctrl dut (
    .clk0(clk0), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level),
    .mem_ce_rw(mem_ce_rw), .mem_we_rw(mem_we_rw), .mem_wmask(mem_wmask),
    .mem_addr_rw(mem_addr_rw), .mem_wdata(mem_wdata),
    .mem_ce_r(mem_ce_r), .mem_addr_r(mem_addr_r), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk0);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    rst = 1; flush = 0; s_valid = 0; s_data = 0; m_ready = 0;
    #1;
    chk("rst_s_ready", s_ready, 0);
    tick; tick;
    rst = 0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready_after", s_ready, 1);
    chk("wmask", mem_wmask, 32'hffffffff);
    // T1 single word
    s_valid = 1; s_data = 32'hdeadbeef;
    #1;
    chk("t1_ce_rw", mem_ce_rw, 1);
    chk("t1_addr_rw", mem_addr_rw, 0);
    chk("t1_wdata", mem_wdata, 32'hdeadbeef);
    tick;
    s_valid = 0;
    #1;
    chk("t1_issue", mem_ce_r, 1);
    chk("t1_level_a", level, 1);
    chk("t1_mvalid_e1", m_valid, 0);
    tick;
    chk("t1_mvalid_e2", m_valid, 0);
    tick;
    chk("t1_mvalid_e3", m_valid, 1);
    chk("t1_mdata", m_data, 32'hdeadbeef);
    chk("t1_level_b", level, 1);
    m_ready = 1;
    tick;
    m_ready = 0;
    chk("t1_mvalid_pop", m_valid, 0);
    chk("t1_level_pop", level, 0);
    // T2 fill
    accepted = 0; wrap = 0; prev_addr = 0;
    for (int i = 0; i < 400; i++) begin
      s_valid = 1; s_data = i;
      #1;
      if (s_ready) begin
        if (prev_addr == 9'd383 && mem_addr_rw == 9'd0) wrap = 1;
        prev_addr = mem_addr_rw;
        accepted++;
      end
      tick;
    end
    s_valid = 0;
    #1;
    chk("t2_accepted", accepted, 386);
    chk("t2_level", level, 386);
    chk("t2_s_ready", s_ready, 0);
    chk("t2_wrap", wrap, 1);
    got = 0; errs = 0; m_ready = 1;
    for (int c = 0; c < 1000 && got < 386; c++) begin
      if (m_valid) begin
        if (m_data !== got) errs++;
        got++;
      end
      tick;
    end
    chk("t2_drain_cnt", got, 386);
    chk("t2_drain_order", errs, 0);
    tick; tick;
    chk("t2_level_empty", level, 0);
    chk("t2_mvalid_empty", m_valid, 0);
    // T3 streaming
    sent = 0; got = 0; errs = 0; bubbles = 0; maxlvl = 0; started = 0; m_ready = 1;
    for (int c = 0; c < 1200 && got < 1000; c++) begin
      s_valid = sent < 1000; s_data = 1000 + sent;
      #1;
      if (s_valid && s_ready) sent++;
      if (m_valid) begin
        started = 1;
        if (m_data !== 1000 + got) errs++;
        got++;
      end else if (started) bubbles++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
      tick;
    end
    s_valid = 0;
    chk("t3_count", got, 1000);
    chk("t3_order", errs, 0);
    chk("t3_bubbles", bubbles, 0);
    chk("t3_level_le3", maxlvl <= 3, 1);
    tick; tick;
    // T4 backpressure
    sent = 0; got = 0; errs = 0;
    for (int c = 0; c < 1000 && got < 200; c++) begin
      s_valid = sent < 200; s_data = 5000 + sent; m_ready = (c % 2) == 0;
      #1;
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) begin
        if (m_data !== 5000 + got) errs++;
        got++;
      end
      tick;
    end
    s_valid = 0; m_ready = 0;
    tick; tick;
    chk("t4_count", got, 200);
    chk("t4_order", errs, 0);
    chk("t4_level", level, 0);
    chk("t4_no_extra", m_valid, 0);
    // T5 flush mid-stream
    for (int i = 0; i < 50; i++) begin
      s_valid = 1; s_data = 7000 + i;
      tick;
    end
    s_valid = 0;
    tick; tick; tick;
    chk("t5_level50", level, 50);
    s_valid = 1; s_data = 32'h0badf00d; m_ready = 1; flush = 1;
    #1;
    chk("t5_fl_s_ready", s_ready, 0);
    chk("t5_fl_m_valid", m_valid, 0);
    chk("t5_fl_ce_r", mem_ce_r, 0);
    chk("t5_fl_ce_rw", mem_ce_rw, 0);
    tick;
    flush = 0; s_valid = 0; m_ready = 0;
    #1;
    chk("t5_level0", level, 0);
    chk("t5_m_valid0", m_valid, 0);
    chk("t5_m_data0", m_data, 0);
    s_valid = 1; s_data = 32'h12345678;
    tick;
    s_valid = 0; m_ready = 1; seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (m_valid) seen = 1;
      else tick;
    end
    chk("t5_seen", seen, 1);
    chk("t5_first", m_data, 32'h12345678);
    tick;
    m_ready = 0;
    chk("t5_level_end", level, 0);
    // T6 reset with read in flight
    s_valid = 1; s_data = 32'haaaa5555;
    tick;
    s_valid = 0;
    chk("t6_issue", mem_ce_r, 1);
    tick;
    rst = 1; s_valid = 1;
    #1;
    chk("t6_s_ready", s_ready, 0);
    chk("t6_m_valid", m_valid, 0);
    chk("t6_ce_r", mem_ce_r, 0);
    chk("t6_ce_rw", mem_ce_rw, 0);
    chk("t6_we_rw", mem_we_rw, 0);
    tick;
    rst = 0; s_valid = 0;
    #1;
    chk("t6_level", level, 0);
    chk("t6_m_valid_after", m_valid, 0);
    chk("t6_m_data", m_data, 0);
    tick; tick;
    chk("t6_no_capture", m_valid, 0);
    chk("t6_level_late", level, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
